memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Arbitrates the single-ported RAM between the instruction-fetch requester and the data-memory requester of the pipelined MIPS datapath. It sequences each access through a small FSM and returns a one-cycle hit plus registered load data. It holds the LL/SC link register that gives `ll`/`sc` their atomic semantics, and decides SC success or failure without touching RAM on failure. It sits between the datapath's memory stage and fetch stage on one side and the RAM model on the other.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data word width.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous reset, active-high.
- `iREN`  in  1  instruction read request; held until `ihit`.
- `iaddr`  in  ADDR_W  instruction address.
- `ihit`  out  1  one-cycle pulse: instruction access complete.
- `iload`  out  DATA_W  fetched instruction; valid while `ihit`=1.
- `dREN`  in  1  data read request (LW, LL).
- `dWEN`  in  1  data write request (SW, SC).
- `datomic`  in  1  qualifies `dREN`/`dWEN` as LL/SC.
- `daddr`  in  ADDR_W  data address.
- `dstore`  in  DATA_W  write data.
- `dhit`  out  1  one-cycle pulse: data access complete.
- `dload`  out  DATA_W  read data. For SC it carries the result: 1 on success, 0 on failure.
- `ramREN`  out  1  RAM read strobe.
- `ramWEN`  out  1  RAM write strobe.
- `ramaddr`  out  ADDR_W  RAM address.
- `ramstore`  out  DATA_W  RAM write data.
- `ramload`  in  DATA_W  RAM read data; valid with `ram_ready`.
- `ram_ready`  in  1  RAM completes the current access this cycle.

## Operation
FSM states are IDLE, DACC, IACC, DRESP, IRESP and SCFAIL.

IDLE:
- Samples the requests. Data request means `dREN|dWEN`.
- Only data pending → DACC.
- Only `iREN` pending → IACC.
- Both pending: grant goes to the requester not granted last (`last_grant` bit). `last_grant` resets to instruction, so the first contest goes to data.
- SC (`dWEN & datomic`) when the link is invalid or the word address (`daddr[31:2]`) does not match `lladdr` → SCFAIL. No RAM access occurs.
- The grant latches `daddr`, `dstore`, the op and `datomic` (or `iaddr`) into internal registers. The RAM outputs are driven from these registers, not from the live inputs.

DACC / IACC:
- Assert `ramREN` (read, or any instruction access) or `ramWEN` (write) with the latched address and data.
- Stay in the state until `ram_ready`.
- On `ram_ready`: capture `ramload` → DRESP / IRESP.

DRESP / IRESP:
- `dhit` / `ihit` = 1 for exactly one cycle, with `dload` / `iload` valid. Update `last_grant`. Next state is IDLE.

SCFAIL:
- `dhit`=1 and `dload`=0 for one cycle. Next state is IDLE.

Link register (`llvalid`, `lladdr[ADDR_W-1:2]`):
- LL completion (DRESP of an atomic read) sets `llvalid`=1 and `lladdr`=latched `daddr[31:2]`.
- SC success: DRESP of an atomic write returns `dload`=1 and clears `llvalid`.
- A plain SW granted to an address matching `lladdr` clears `llvalid` at its DRESP.
- SW to other addresses, LW and fetches leave the link unchanged.
- A new LL overwrites the link.

Other rules:
- Requests dropped mid-access are ignored; the latched access completes and its hit is still pulsed.
- Requests are not re-sampled during the RESP cycle, so a requester holding its request through the hit is not double-served.
- `dREN` and `dWEN` both high: treated as a write.

## Timing
- Reset:
  - State = IDLE.
  - `ihit`, `dhit`, `ramREN`, `ramWEN` = 0.
  - `iload`, `dload`, `ramaddr`, `ramstore` = 0.
  - `llvalid`=0 and `last_grant`=instruction.
  - Reset asserted mid-access aborts the access immediately. No hit is issued.
- Latency: request seen in IDLE at cycle 0; RAM strobe from cycle 1; `ram_ready` at cycle k≥1; hit at k+1; IDLE at k+2. The minimum access is 3 cycles, request to IDLE.
- Failed SC: hit at cycle 1, IDLE at cycle 2.
- RAM strobes are driven only in DACC/IACC and go low the cycle after `ram_ready`.
- Back-to-back contested requests alternate grants: D, I, D, I.

## Test plan
- Instruction only: `iREN`=1, `iaddr`=0x40, `ram_ready` at cycle 2, `ramload`=0x20010005 → `ramREN`=1 at cycles 1–2; `ihit`=1 with `iload`=0x20010005 at cycle 3.
- Contention: `iREN` and `dREN` high continuously from reset → grant order D, I, D, I. No hit is lost, and each hit is exactly one cycle.
- LL/SC success: LL at 0x100 → link set; SC at 0x100 with `dstore`=0xA → `ramWEN`=1, `ramstore`=0xA, `dload`=1, and the link is cleared.
- SC failure via intervening store: LL at 0x100, then SW to 0x100, then SC at 0x100 → no `ramWEN` for the SC; `dhit` one cycle after request with `dload`=0.
- SW to an unrelated address: LL at 0x100, SW to 0x200, then SC at 0x100 → SC succeeds with `dload`=1.
- Reset mid-access: assert `RST` during DACC before `ram_ready` → all outputs go to 0 immediately with no `dhit`; a subsequent SC fails because the link was cleared.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates fetch and data requesters onto one RAM port and holds the LL/SC link
module memory_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              datomic,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
);
  typedef enum logic [2:0] {IDLE, DACC, IACC, DRESP, IRESP, SCFAIL} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, load_q;
  logic [ADDR_W-3:0] lla_q;
  logic wr_q, atom_q, llv_q, lg_q;
  logic grant_d, sc_fail;
  // next state: data wins unless it was served last and fetch is also waiting
  always_comb begin
    grant_d = (dREN | dWEN) & (~iREN | ~lg_q);
    sc_fail = dWEN & datomic & (~llv_q | (daddr[ADDR_W-1:2] != lla_q));
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grant_d ? (sc_fail ? SCFAIL : DACC) : (iREN ? IACC : IDLE);
      DACC:    state_d = ram_ready ? DRESP : DACC;
      IACC:    state_d = ram_ready ? IRESP : IACC;
      default: state_d = IDLE;
    endcase
  end
  assign ramREN   = (state_q == IACC) | ((state_q == DACC) & ~wr_q);
  assign ramWEN   = (state_q == DACC) & wr_q;
  assign ramaddr  = addr_q;
  assign ramstore = data_q;
  assign ihit     = (state_q == IRESP);
  assign dhit     = (state_q == DRESP) | (state_q == SCFAIL);
  assign iload    = load_q;
  assign dload    = load_q;
  // state register, latched request, response data, link and fairness bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      load_q  <= '0;
      lla_q   <= '0;
      wr_q    <= 1'b0;
      atom_q  <= 1'b0;
      llv_q   <= 1'b0;
      lg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (grant_d) begin
          addr_q <= daddr;
          data_q <= dstore;
          wr_q   <= dWEN;
          atom_q <= datomic;
          load_q <= '0;
        end else if (iREN) begin
          addr_q <= iaddr;
          wr_q   <= 1'b0;
          atom_q <= 1'b0;
        end
        DACC: if (ram_ready) load_q <= wr_q ? DATA_W'(atom_q) : ramload;
        IACC: if (ram_ready) load_q <= ramload;
        DRESP: begin
          lg_q <= 1'b1;
          if (!wr_q && atom_q) begin
            llv_q <= 1'b1;
            lla_q <= addr_q[ADDR_W-1:2];
          end else if (wr_q && (atom_q || addr_q[ADDR_W-1:2] == lla_q)) llv_q <= 1'b0;
        end
        IRESP:   lg_q <= 1'b0;
        SCFAIL:  lg_q <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed checks of arbitration, latency and LL/SC behaviour
module tb_memory_arbiter;
  logic CLK = 1'b0, RST = 1'b1;
  logic iREN = 0, dREN = 0, dWEN = 0, datomic = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0;
  logic ihit, dhit, ramREN, ramWEN, ram_ready;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [31:0] mem [256];
  int lat = 2, cnt;
  int vectors = 0, miss = 0;

  memory_arbiter dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  // RAM model: completes after lat strobed cycles; two fixed words at 0x40/0x44
  assign ram_ready = (ramREN || ramWEN) && (cnt == lat - 1);
  assign ramload = (ramaddr == 32'h40) ? 32'h20010005 :
                   (ramaddr == 32'h44) ? 32'hDEADBEEF : mem[ramaddr[9:2]];
  always @(posedge CLK or posedge RST) begin
    if (RST) cnt <= 0;
    else begin
      cnt <= ((ramREN || ramWEN) && !ram_ready) ? cnt + 1 : 0;
      if (ramWEN && ram_ready) mem[ramaddr[9:2]] <= ramstore;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // issue one data request at a negedge; report load, cycles to hit, write strobe seen
  task automatic dacc(input logic rn, input logic wn, input logic at, input logic [31:0] a,
                      input logic [31:0] s, output logic [31:0] ld, output int cyc,
                      output logic sw, output logic [31:0] ws);
    dREN = rn; dWEN = wn; datomic = at; daddr = a; dstore = s;
    ld = 'x; cyc = 0; sw = 0; ws = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (ramWEN) begin sw = 1; ws = ramstore; end
      if (dhit) begin cyc = i; ld = dload; break; end
    end
    dREN = 0; dWEN = 0; datomic = 0;
    @(negedge CLK);
  endtask

  logic [31:0] ld, ws;
  logic sw;
  int cyc;
  int nh, both, rep;
  logic [3:0] order;
  logic pi, pd;

  initial begin
    #1;
    chk("rst_ihit", ihit, 0);
    chk("rst_dhit", dhit, 0);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    @(negedge CLK);
    RST = 0;
    @(negedge CLK);
    // instruction fetch, RAM ready on second strobed cycle
    iREN = 1; iaddr = 32'h40;
    @(negedge CLK);
    chk("if_c1_ren", ramREN, 1);
    chk("if_c1_addr", ramaddr, 32'h40);
    @(negedge CLK);
    chk("if_c2_ren", ramREN, 1);
    chk("if_c2_hit", ihit, 0);
    @(negedge CLK);
    chk("if_c3_hit", ihit, 1);
    chk("if_c3_load", iload, 32'h20010005);
    chk("if_c3_ren", ramREN, 0);
    iREN = 0;
    @(negedge CLK);
    chk("if_c4_hit", ihit, 0);
    // contention held from reset: expect D, I, D, I with hits at cycles 2,5,8,11
    RST = 1; lat = 1; iREN = 1; dREN = 1; iaddr = 32'h40; daddr = 32'h44;
    @(negedge CLK);
    RST = 0;
    nh = 0; both = 0; rep = 0; order = 0; pi = 0; pd = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge CLK);
      if (ihit && dhit) both++;
      if ((ihit && pi) || (dhit && pd)) rep++;
      if (ihit || dhit) begin
        nh++;
        order = {order[2:0], ihit};
        chk("cont_load", ihit ? iload : dload, ihit ? 32'h20010005 : 32'hDEADBEEF);
      end
      pi = ihit; pd = dhit;
    end
    iREN = 0; dREN = 0;
    @(negedge CLK);
    chk("cont_hits", nh, 4);
    chk("cont_order", {28'd0, order}, 32'b0101);
    chk("cont_both", both, 0);
    chk("cont_repeat", rep, 0);
    // LL then successful SC
    dacc(0, 1, 0, 32'h100, 32'h1234, ld, cyc, sw, ws);
    dacc(1, 0, 1, 32'h100, 0, ld, cyc, sw, ws);
    chk("ll_load", ld, 32'h1234);
    chk("ll_lat", cyc, 2);
    dacc(0, 1, 1, 32'h100, 32'hA, ld, cyc, sw, ws);
    chk("sc_ok", ld, 1);
    chk("sc_wen", {31'd0, sw}, 1);
    chk("sc_store", ws, 32'hA);
    chk("sc_lat", cyc, 2);
    dacc(0, 1, 1, 32'h100, 32'hB, ld, cyc, sw, ws);
    chk("sc_again", ld, 0);
    chk("sc_again_wen", {31'd0, sw}, 0);
    chk("sc_again_lat", cyc, 1);
    dacc(1, 0, 0, 32'h100, 0, ld, cyc, sw, ws);
    chk("lw_after_sc", ld, 32'hA);
    // intervening store to the linked word breaks the link
    dacc(1, 0, 1, 32'h100, 0, ld, cyc, sw, ws);
    dacc(0, 1, 0, 32'h100, 32'h5, ld, cyc, sw, ws);
    dacc(0, 1, 1, 32'h100, 32'h6, ld, cyc, sw, ws);
    chk("sw_kill_sc", ld, 0);
    chk("sw_kill_wen", {31'd0, sw}, 0);
    chk("sw_kill_lat", cyc, 1);
    // store elsewhere keeps the link
    dacc(1, 0, 1, 32'h100, 0, ld, cyc, sw, ws);
    chk("ll2_load", ld, 32'h5);
    dacc(0, 1, 0, 32'h200, 32'h7, ld, cyc, sw, ws);
    dacc(0, 1, 1, 32'h100, 32'h8, ld, cyc, sw, ws);
    chk("sw_other_sc", ld, 1);
    dacc(1, 0, 0, 32'h200, 0, ld, cyc, sw, ws);
    chk("lw_200", ld, 32'h7);
    // byte offsets within the linked word still match; next word does not
    dacc(1, 0, 1, 32'h100, 0, ld, cyc, sw, ws);
    dacc(0, 1, 1, 32'h103, 32'h9, ld, cyc, sw, ws);
    chk("sc_same_word", ld, 1);
    dacc(1, 0, 1, 32'h100, 0, ld, cyc, sw, ws);
    dacc(0, 1, 1, 32'h104, 32'h9, ld, cyc, sw, ws);
    chk("sc_next_word", ld, 0);
    // reset in the middle of a slow access
    lat = 4;
    dREN = 1; daddr = 32'h300;
    @(negedge CLK);
    chk("mid_c1_ren", ramREN, 1);
    @(negedge CLK);
    RST = 1;
    #1;
    chk("mid_ren", ramREN, 0);
    chk("mid_wen", ramWEN, 0);
    chk("mid_dhit", dhit, 0);
    chk("mid_addr", ramaddr, 0);
    chk("mid_dload", dload, 0);
    dREN = 0;
    @(negedge CLK);
    RST = 0; lat = 1;
    @(negedge CLK);
    chk("post_rst_dhit", dhit, 0);
    dacc(0, 1, 1, 32'h100, 32'hC, ld, cyc, sw, ws);
    chk("post_rst_sc", ld, 0);
    chk("post_rst_lat", cyc, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
